// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with load-use stall, branch flush and ECALL drain-and-halt FSM.
// Optional feature macro HAZARD_STALL_EN enables hardware load-use stall detection.
module id_ex_stage #(
  parameter int DRAIN_CYCLES = 3,
  parameter int BUBBLE_CNT_W = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    id_valid,
  input  logic [31:0]             id_pc,
  input  logic [4:0]              id_opcode,
  input  logic [2:0]              id_func3,
  input  logic                    id_func7,
  input  logic [4:0]              id_rs1,
  input  logic [4:0]              id_rs2,
  input  logic [4:0]              id_rd,
  input  logic [31:0]             id_imm,
  input  logic [3:0]              id_dm_w_en,
  input  logic                    id_wb_en,
  input  logic                    id_jb_src1_sel,
  input  logic                    id_alu_src1_sel,
  input  logic                    id_alu_src2_sel,
  input  logic                    id_wb_sel,
  input  logic                    id_ecall,
  input  logic                    ex_branch_taken,
  output logic                    stall_id,
  output logic                    ex_valid,
  output logic [31:0]             ex_pc,
  output logic [31:0]             ex_imm,
  output logic [4:0]              ex_opcode,
  output logic [2:0]              ex_func3,
  output logic                    ex_func7,
  output logic [4:0]              ex_rs1,
  output logic [4:0]              ex_rs2,
  output logic [4:0]              ex_rd,
  output logic [3:0]              ex_dm_w_en,
  output logic                    ex_wb_en,
  output logic                    ex_jb_src1_sel,
  output logic                    ex_alu_src1_sel,
  output logic                    ex_alu_src2_sel,
  output logic                    ex_wb_sel,
  output logic                    ex_ecall,
  output logic                    halt,
  output logic [BUBBLE_CNT_W-1:0] bubble_cnt
);
  localparam int CW = DRAIN_CYCLES > 1 ? $clog2(DRAIN_CYCLES) : 1;
  typedef enum logic [1:0] {RUN, DRAIN, HALT} state_t;
  state_t r_state, w_state_nxt;
  logic [CW-1:0] r_drain, w_drain_nxt;
  logic w_ecall_ex, w_busy, w_load_use, w_bubble;
  assign w_ecall_ex = ex_valid & ex_ecall;
  assign w_busy     = (r_state != RUN) | w_ecall_ex;
`ifdef HAZARD_STALL_EN
  logic w_rs1_used, w_rs2_used;
  assign w_rs1_used = !(id_opcode inside {5'b01101, 5'b00101, 5'b11011});
  assign w_rs2_used = id_opcode inside {5'b01100, 5'b11000, 5'b01000};
  assign w_load_use = ex_valid & ex_wb_sel & (ex_rd != 5'd0) & id_valid &
                      ((w_rs1_used & (id_rs1 == ex_rd)) | (w_rs2_used & (id_rs2 == ex_rd)));
`else
  assign w_load_use = 1'b0;
`endif
  // A flush discards the ID instruction, so a coincident load-use need not hold it.
  assign stall_id = w_busy | (w_load_use & ~ex_branch_taken);
  assign w_bubble = w_busy | ex_branch_taken | w_load_use;
  assign halt     = r_state == HALT;
  // Next state: enter DRAIN on a valid ECALL in EX, count down, then park in HALT.
  always_comb begin
    w_state_nxt = r_state;
    w_drain_nxt = r_drain;
    if (r_state == RUN && w_ecall_ex) begin
      w_state_nxt = DRAIN;
      w_drain_nxt = CW'(DRAIN_CYCLES - 1);
    end else if (r_state == DRAIN) begin
      w_state_nxt = r_drain == '0 ? HALT : DRAIN;
      w_drain_nxt = r_drain == '0 ? r_drain : r_drain - 1'b1;
    end
  end
  // State and drain counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= RUN;
      r_drain <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_drain <= w_drain_nxt;
    end
  end
  // EX register: bubble on reset/drain/flush/stall, else latch ID with control gated by id_valid.
  always_ff @(posedge clk) begin
    if (rst || w_bubble) begin
      ex_valid        <= 1'b0;
      ex_pc           <= '0;
      ex_imm          <= '0;
      ex_opcode       <= '0;
      ex_func3        <= '0;
      ex_func7        <= 1'b0;
      ex_rs1          <= '0;
      ex_rs2          <= '0;
      ex_rd           <= '0;
      ex_dm_w_en      <= '0;
      ex_wb_en        <= 1'b0;
      ex_jb_src1_sel  <= 1'b0;
      ex_alu_src1_sel <= 1'b0;
      ex_alu_src2_sel <= 1'b0;
      ex_wb_sel       <= 1'b0;
      ex_ecall        <= 1'b0;
    end else begin
      ex_valid        <= id_valid;
      ex_pc           <= id_pc;
      ex_imm          <= id_imm;
      ex_opcode       <= id_opcode;
      ex_func3        <= id_func3;
      ex_func7        <= id_func7;
      ex_rs1          <= id_rs1;
      ex_rs2          <= id_rs2;
      ex_rd           <= id_rd;
      ex_dm_w_en      <= id_valid ? id_dm_w_en : 4'b0000;
      ex_wb_en        <= id_valid & id_wb_en;
      ex_jb_src1_sel  <= id_jb_src1_sel;
      ex_alu_src1_sel <= id_alu_src1_sel;
      ex_alu_src2_sel <= id_alu_src2_sel;
      ex_wb_sel       <= id_wb_sel;
      ex_ecall        <= id_valid & id_ecall;
    end
  end
  // Saturating count of inserted bubbles.
  always_ff @(posedge clk) begin
    if (rst) bubble_cnt <= '0;
    else if (w_bubble && !(&bubble_cnt)) bubble_cnt <= bubble_cnt + 1'b1;
  end
endmodule
